// File: rtl/seg_scan_reader.sv
// seg_scan_reader
//   Recovers the digits shown on a multiplexed, active-low 7-segment display
//   by observing the segment and digit-enable buses. A digit is accepted
//   once its select/segment pair has stayed unchanged for STABLE_CYC cycles.
//   After all four digits have been seen, the assembled frame is presented
//   on a valid/ready output.
//
// Parameters
//   STABLE_CYC  consecutive unchanged cycles required before capture (2..255)
//
// Ports
//   CLK     in   1   clock, rising edge
//   RST     in   1   synchronous active-high reset
//   SEG     in   7   segment bus, active-low, bit order gfedcba
//   DIG     in   4   digit enables, active-low one-hot, DIG[i] selects digit i
//   OREADY  in   1   consumer ready
//   ODATA   out  16  decoded frame, digit i in bits [4i+3:4i]
//   OERR    out  4   per-digit flag, 1 = digit pattern unrecognised
//   OVALID  out  1   frame available, held until transferred
//   OVF     out  1   sticky, a completed frame was dropped since last transfer

module seg_scan_reader #(
  parameter int unsigned STABLE_CYC = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [6:0]  SEG,
  input  logic [3:0]  DIG,
  input  logic        OREADY,
  output logic [15:0] ODATA,
  output logic [3:0]  OERR,
  output logic        OVALID,
  output logic        OVF
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HELD
  } state_t;

  localparam logic [7:0] STABLE_TGT = 8'(STABLE_CYC);

  // Registered observation pair and its one-cycle-delayed copy
  logic [6:0]  p_seg;
  logic [3:0]  p_dig;
  logic [6:0]  prev_seg;
  logic [3:0]  prev_dig;

  // Digit select decode
  logic        sel_ok;
  logic [1:0]  sel_idx;

  // Stability tracking
  state_t      state;
  state_t      state_nx;
  logic [7:0]  cnt;
  logic [7:0]  cnt_nx;
  logic        changed;
  logic        at_target;
  logic        capture;

  // Segment decode
  logic [3:0]  code;
  logic        code_bad;

  // Frame assembly
  logic [15:0] asm_data;
  logic [3:0]  asm_err;
  logic [3:0]  mask;
  logic [3:0]  cap_bit;
  logic        complete;

  // Output handshake
  logic        xfer;
  logic        load;
  logic        drop;

  // ------------------------------------------------------------------
  // Input registers: nothing downstream looks at SEG/DIG directly.
  // ------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      p_seg    <= '1;
      p_dig    <= '1;
      prev_seg <= '1;
      prev_dig <= '1;
    end else begin
      p_seg    <= SEG;
      p_dig    <= DIG;
      prev_seg <= p_seg;
      prev_dig <= p_dig;
    end
  end

  // Exactly one low enable bit selects a digit; anything else is no select.
  always_comb begin
    sel_ok  = 1'b1;
    sel_idx = 2'd0;
    case (p_dig)
      4'b1110: sel_idx = 2'd0;
      4'b1101: sel_idx = 2'd1;
      4'b1011: sel_idx = 2'd2;
      4'b0111: sel_idx = 2'd3;
      default: sel_ok  = 1'b0;
    endcase
  end

  assign changed   = (p_seg != prev_seg) || (p_dig != prev_dig);
  assign at_target = (cnt + 8'd1) == STABLE_TGT;

  // ------------------------------------------------------------------
  // Stability FSM
  // ------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (changed) begin
      state_nx = sel_ok ? SETTLE : IDLE;
    end else begin
      case (state)
        IDLE:    state_nx = IDLE;
        SETTLE:  state_nx = at_target ? HELD : SETTLE;
        HELD:    state_nx = HELD;
        default: state_nx = IDLE;
      endcase
    end
  end

  // A pair first seen on edge N is recognised as new on N+1; the counter
  // then advances on each later unchanged edge, so capture lands on edge
  // N+STABLE_CYC+1.
  always_comb begin
    capture = 1'b0;
    cnt_nx  = cnt;
    if (changed) begin
      cnt_nx = '0;
    end else begin
      case (state)
        IDLE: cnt_nx = '0;
        SETTLE: begin
          cnt_nx  = cnt + 8'd1;
          capture = at_target;
        end
        HELD:    cnt_nx = cnt;
        default: cnt_nx = '0;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nx;
    end
  end

  // ------------------------------------------------------------------
  // Segment decode (active-low, gfedcba)
  // ------------------------------------------------------------------
  always_comb begin
    code_bad = 1'b0;
    code     = 4'hF;
    case (p_seg)
      7'b1000000: code = 4'h0;
      7'b1111001: code = 4'h1;
      7'b0100100: code = 4'h2;
      7'b0110000: code = 4'h3;
      7'b0011001: code = 4'h4;
      7'b0010010: code = 4'h5;
      7'b0000010: code = 4'h6;
      7'b1111000: code = 4'h7;
      7'b0000000: code = 4'h8;
      7'b0010000: code = 4'h9;
      7'b0111111: code = 4'hE;
      default: begin
        code     = 4'hF;
        code_bad = 1'b1;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Frame assembly
  // ------------------------------------------------------------------
  assign cap_bit  = capture ? (4'b0001 << sel_idx) : 4'b0000;
  assign complete = (mask == 4'hF);

  // The mask clears on the edge after it fills; a capture on that same edge
  // still registers its bit so no digit is lost.
  always_ff @(posedge CLK) begin
    if (RST) begin
      asm_data <= '0;
      asm_err  <= '0;
      mask     <= '0;
    end else begin
      if (capture) begin
        asm_data[{sel_idx, 2'b00} +: 4] <= code;
        asm_err[sel_idx]                <= code_bad;
      end
      mask <= (complete ? 4'b0000 : mask) | cap_bit;
    end
  end

  // ------------------------------------------------------------------
  // Output register and handshake
  // ------------------------------------------------------------------
  assign xfer = OVALID & OREADY;
  assign load = complete & (~OVALID | OREADY);
  assign drop = complete & OVALID & ~OREADY;

  always_ff @(posedge CLK) begin
    if (RST) begin
      ODATA  <= '0;
      OERR   <= '0;
      OVALID <= 1'b0;
      OVF    <= 1'b0;
    end else begin
      if (load) begin
        ODATA  <= asm_data;
        OERR   <= asm_err;
        OVALID <= 1'b1;
      end else if (xfer) begin
        OVALID <= 1'b0;
      end

      if (xfer) begin
        OVF <= 1'b0;
      end else if (drop) begin
        OVF <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_reader.sv
// tb_seg_scan_reader
//   Directed bench for seg_scan_reader (STABLE_CYC = 4). Expected frames are
//   queued when the digits are driven and compared when the frame appears.

module tb_seg_scan_reader;

  logic        CLK;
  logic        RST;
  logic [6:0]  SEG;
  logic [3:0]  DIG;
  logic        OREADY;
  logic [15:0] ODATA;
  logic [3:0]  OERR;
  logic        OVALID;
  logic        OVF;

  localparam logic [3:0] D0   = 4'b1110;
  localparam logic [3:0] D1   = 4'b1101;
  localparam logic [3:0] D2   = 4'b1011;
  localparam logic [3:0] D3   = 4'b0111;
  localparam logic [3:0] NONE = 4'b1111;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SDASH  = 7'b0111111;
  localparam logic [6:0] SBLANK = 7'b1111111;
  localparam logic [6:0] SBAD   = 7'b1010101;

  int unsigned total  = 0;
  int unsigned passed = 0;

  // {OERR, ODATA}
  logic [19:0] sb[$];

  seg_scan_reader #(.STABLE_CYC(4)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .SEG    (SEG),
    .DIG    (DIG),
    .OREADY (OREADY),
    .ODATA  (ODATA),
    .OERR   (OERR),
    .OVALID (OVALID),
    .OVF    (OVF)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [3:0] d, input logic [6:0] s);
    DIG = d;
    SEG = s;
  endtask

  task automatic show(input logic [3:0] d, input logic [6:0] s);
    drive(d, s);
    tick(8);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!OVALID && n < 50) begin
      tick(1);
      n++;
    end
    chk(tag, 32'(OVALID), 32'd1);
  endtask

  task automatic compare_head(input string tag);
    logic [19:0] e;
    chk({tag, "_avail"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_odata"}, 32'(ODATA), 32'(e[15:0]));
      chk({tag, "_oerr"},  32'(OERR),  32'(e[19:16]));
    end
  endtask

  task automatic transfer();
    OREADY = 1'b1;
    tick(1);
    OREADY = 1'b0;
  endtask

  initial begin
    RST    = 1'b1;
    SEG    = '1;
    DIG    = '1;
    OREADY = 1'b0;
    tick(3);
    chk("rst_odata",  32'(ODATA),  32'h0);
    chk("rst_oerr",   32'(OERR),   32'h0);
    chk("rst_ovalid", 32'(OVALID), 32'h0);
    chk("rst_ovf",    32'(OVF),    32'h0);
    RST = 1'b0;
    tick(2);

    // Basic frame with exact capture latency on the last digit
    sb.push_back({4'h0, 16'h4312});
    show(D0, S2);
    show(D1, S1);
    show(D2, S3);
    drive(D3, S4);
    tick(5);
    drive(NONE, SBLANK);
    tick(1);
    chk("lat_edge5_novalid", 32'(OVALID), 32'd0);
    tick(1);
    chk("lat_edge6_valid", 32'(OVALID), 32'd1);
    compare_head("f1");
    transfer();
    chk("f1_xfer_ovalid", 32'(OVALID), 32'd0);
    chk("f1_xfer_ovf",    32'(OVF),    32'd0);
    chk("f1_retain",      32'(ODATA),  32'h4312);

    // Short pulse ignored; glitch restarts settle
    sb.push_back({4'h0, 16'h9760});
    show(D0, S0);
    show(D1, S6);
    show(D2, S7);
    drive(D3, S1);
    tick(2);
    drive(NONE, SBLANK);
    tick(10);
    chk("pulse_nocapture", 32'(OVALID), 32'd0);
    drive(D3, S8);
    tick(3);
    drive(D3, S9);
    tick(5);
    drive(NONE, SBLANK);
    tick(1);
    chk("glitch_no_early", 32'(OVALID), 32'd0);
    tick(1);
    chk("glitch_valid", 32'(OVALID), 32'd1);
    compare_head("f2");
    transfer();

    // Unrecognised patterns, dash, and recapture clearing an error bit
    sb.push_back({4'b0100, 16'hEF85});
    show(D0, SBLANK);
    show(D1, S8);
    show(D0, S5);
    show(D2, SBAD);
    show(D3, SDASH);
    wait_valid("f3_wait");
    compare_head("f3");
    transfer();

    // Overflow: second frame dropped while first is unconsumed
    sb.push_back({4'h0, 16'h4321});
    show(D0, S1);
    show(D1, S2);
    show(D2, S3);
    show(D3, S4);
    wait_valid("f4_wait");
    compare_head("f4");
    show(D0, S9);
    show(D1, S9);
    show(D2, S9);
    show(D3, S9);
    drive(NONE, SBLANK);
    tick(3);
    chk("ovf_set",        32'(OVF),    32'd1);
    chk("ovf_hold_data",  32'(ODATA),  32'h4321);
    chk("ovf_hold_valid", 32'(OVALID), 32'd1);
    transfer();
    chk("ovf_xfer_ovalid", 32'(OVALID), 32'd0);
    chk("ovf_xfer_ovf",    32'(OVF),    32'd0);

    // Transfer and new load on the same edge
    sb.push_back({4'h0, 16'h5678});
    show(D0, S8);
    show(D1, S7);
    show(D2, S6);
    show(D3, S5);
    wait_valid("f6_wait");
    compare_head("f6");
    sb.push_back({4'h0, 16'h2E10});
    show(D0, S0);
    show(D1, S1);
    show(D2, SDASH);
    drive(D3, S2);
    tick(5);
    drive(NONE, SBLANK);
    tick(1);
    OREADY = 1'b1;
    tick(1);
    OREADY = 1'b0;
    chk("same_edge_ovalid", 32'(OVALID), 32'd1);
    compare_head("f7");
    chk("same_edge_ovf", 32'(OVF), 32'd0);
    transfer();
    chk("f7_xfer_ovalid", 32'(OVALID), 32'd0);

    // Invalid selects never capture
    sb.push_back({4'h0, 16'h3210});
    show(D0, S0);
    show(D1, S1);
    show(D2, S2);
    drive(4'b1100, S5);
    tick(20);
    drive(NONE, S5);
    tick(20);
    chk("badsel_nocapture", 32'(OVALID), 32'd0);
    show(D3, S3);
    wait_valid("f8_wait");
    compare_head("f8");
    transfer();

    // Reset mid-frame discards partial capture
    show(D0, S7);
    show(D1, S7);
    show(D2, S7);
    RST = 1'b1;
    drive(NONE, SBLANK);
    tick(1);
    chk("midrst_odata",  32'(ODATA),  32'h0);
    chk("midrst_ovalid", 32'(OVALID), 32'd0);
    RST = 1'b0;
    tick(1);
    sb.push_back({4'h0, 16'h9111});
    show(D3, S9);
    tick(10);
    chk("midrst_partial", 32'(OVALID), 32'd0);
    show(D0, S1);
    show(D1, S1);
    show(D2, S1);
    wait_valid("f9_wait");
    compare_head("f9");
    transfer();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/seg_scan_reader.md
SEG_SCAN_READER -- requirements
Module: seg_scan_reader

Interface
REQ-001 Parameter STABLE_CYC, default 4, meaning the number of consecutive unchanged cycles required before a digit is captured (legal range 2-255).
REQ-002 CLK  in  1  single clock; all logic on rising edge.
REQ-003 RST  in  1  reset, synchronous and active-high.
REQ-004 SEG  in  7  observed segment bus, active-low, bit order gfedcba (bit6=g, bit0=a).
REQ-005 DIG  in  4  observed digit enables, active-low one-hot, DIG[i] selects digit i.
REQ-006 OREADY  in  1  consumer ready; a frame transfers on any cycle where OVALID and OREADY are both 1.
REQ-007 ODATA  out  16  decoded frame, digit i in bits [4i+3:4i].
REQ-008 OERR  out  4  per-digit flag, 1 = pattern of digit i was unrecognised.
REQ-009 OVALID  out  1  frame available, held until transfer.
REQ-010 OVF  out  1  sticky, a completed frame was dropped since the last transfer.

Function
REQ-011 SEG and DIG SHALL be registered once (pair P) before any use.
REQ-012 The digit select SHALL be valid only when exactly one DIG bit is 0; all-ones or multiple zeros means no digit selected, and the stability counter SHALL clear.
REQ-013 States SHALL be IDLE (no valid digit), SETTLE (counting stability), HELD (digit captured, waiting for a change); any change of P SHALL return to SETTLE (valid select) or IDLE (invalid select) and clear the counter.
REQ-014 In SETTLE, the counter SHALL increment each cycle P is unchanged; on the cycle it reaches STABLE_CYC the digit SHALL be captured and the state SHALL move to HELD; no recapture while in HELD.
REQ-015 Latency: pair applied at the inputs before edge 0 and held SHALL be captured at edge STABLE_CYC+1.
REQ-016 Decode (SEG -> code): 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4, 0010010->5, 0000010->6, 1111000->7, 0000000->8, 0010000->9, 0111111 (dash)->4'hE; the decode SHALL be bit-exact.
REQ-017 Any other pattern, including 1111111 (blank), SHALL decode to 4'hF and set that digit's error bit in the frame being assembled; a recognised capture SHALL clear it.
REQ-018 Capture SHALL write the code into nibble i of an assembly buffer and set bit i of a 4-bit capture mask; recapture of a digit already in the mask SHALL overwrite its nibble and error bit.
REQ-019 When the mask becomes 1111, the frame SHALL be complete: on the next edge the buffer and error bits SHALL load into ODATA/OERR, OVALID SHALL set, and the mask SHALL clear.
REQ-020 If OVALID=1 and OREADY=0 when a frame completes, ODATA/OERR SHALL hold, the new frame SHALL be dropped, the mask SHALL still clear, and OVF SHALL set.
REQ-021 If a transfer and a frame load occur on the same edge, the new frame SHALL load and OVALID SHALL stay 1.
REQ-022 A transfer with no frame load SHALL clear OVALID; ODATA/OERR SHALL retain their last values; OVF SHALL clear on any transfer.
REQ-023 ODATA, OERR, OVALID and OVF SHALL be registered outputs with no combinational path from inputs.

Reset
REQ-024 While RST=1: ODATA=16'h0000, OERR=4'h0, OVALID=0, OVF=0, mask=0, counter=0, state=IDLE, input registers=all ones.
REQ-025 RST asserted mid-frame SHALL discard any partial frame; the first post-reset frame SHALL require all four digits to be captured again.

Verification
REQ-026 STABLE_CYC=4; DIG=1110, SEG=0100100 held -> digit 0 captured at edge 5; scan 1101/1111001, 1011/0110000, 0111/0011001 -> OVALID=1, ODATA=16'h4312, OERR=0.
REQ-027 Glitch: SEG changes on cycle 3 of a settle -> no capture until 5 further edges after the change; a 2-cycle pulse is never captured.
REQ-028 Bad pattern 1010101 on digit 2 plus dash on digit 3 -> ODATA=16'hEF__ per digits 1/0, OERR=4'b0100.
REQ-029 OREADY=0 through two full scans -> first frame held, OVF=1; OREADY=1 for one cycle -> OVALID=0, OVF=0.
REQ-030 DIG=1100 or 1111 held for 20 cycles -> no capture, mask unchanged; RST pulse after 3 digits captured -> no OVALID until 4 new captures.
